// File: rtl/zeroskip_tile_sched.sv
// zeroskip_tile_sched
// Tile-level scheduler in front of zeroskip_pipe_wrapper_MAC256. It accepts a
// command (tile count, sparsity mode), gates the activation and ZNZ-mask
// streams into the wrapper on tile boundaries, bounds tiles in flight with a
// credit check, and counts encoded-output beats to report completion.
// Ports:
//   clk, a_rst_n                    clock, async active-low reset
//   cmd_vld_i/cmd_rdy_o             command handshake (ready only in IDLE)
//   cmd_tiles_i, cmd_mode_i         tile count (0 legal), group_nz_sel
//   s_act_* / m_act_*               activation stream, upstream -> wrapper
//   s_znz_* / m_znz_*               ZNZ mask stream, upstream -> wrapper
//   mon_enc_vld_i, mon_enc_rdy_i    wrapper output handshake taps
//   enable_o, group_nz_sel_o        wrapper controls
//   busy_o, done_o, err_o           status
//   tiles_done_o                    tiles completed in current/last command
module zeroskip_tile_sched #(
  parameter int ACT_DATA_W      = 256,
  parameter int ZNZ_DATA_W      = 512,
  parameter int ACT_BEATS       = 16,
  parameter int ZNZ_BEATS       = 1,
  parameter int ENC_BEATS       = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic                  cmd_vld_i,
  output logic                  cmd_rdy_o,
  input  logic [15:0]           cmd_tiles_i,
  input  logic                  cmd_mode_i,
  input  logic [ACT_DATA_W-1:0] s_act_data_i,
  input  logic                  s_act_vld_i,
  output logic                  s_act_rdy_o,
  output logic [ACT_DATA_W-1:0] m_act_data_o,
  output logic                  m_act_vld_o,
  input  logic                  m_act_rdy_i,
  input  logic [ZNZ_DATA_W-1:0] s_znz_data_i,
  input  logic                  s_znz_vld_i,
  output logic                  s_znz_rdy_o,
  output logic [ZNZ_DATA_W-1:0] m_znz_data_o,
  output logic                  m_znz_vld_o,
  input  logic                  m_znz_rdy_i,
  input  logic                  mon_enc_vld_i,
  input  logic                  mon_enc_rdy_i,
  output logic                  enable_o,
  output logic                  group_nz_sel_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           tiles_done_o
);

  localparam int AB_W = (ACT_BEATS > 1) ? $clog2(ACT_BEATS) : 1;
  localparam int ZB_W = (ZNZ_BEATS > 1) ? $clog2(ZNZ_BEATS) : 1;
  localparam int EB_W = (ENC_BEATS > 1) ? $clog2(ENC_BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [15:0]     tiles;
  logic [15:0]     act_tile;
  logic [15:0]     znz_tile;
  logic [15:0]     tiles_done;
  logic [AB_W-1:0] act_beat;
  logic [ZB_W-1:0] znz_beat;
  logic [EB_W-1:0] enc_beat;
  logic            mode;
  logic            err;

  logic            active;
  logic            act_en;
  logic            znz_en;
  logic            act_hs;
  logic            znz_hs;
  logic            enc_hs;
  logic            act_last;
  logic            znz_last;
  logic            enc_last;
  logic [15:0]     act_inflight;
  logic [15:0]     znz_inflight;
  logic [15:0]     max_tile;
  logic            tile_out;
  logic            out_err;
  logic [15:0]     tiles_done_nxt;

  always_comb begin
    active       = (state == S_RUN) || (state == S_DRAIN);
    act_inflight = act_tile - tiles_done;
    znz_inflight = znz_tile - tiles_done;
    // Credit check only gates the first beat of a tile; a started tile runs to completion.
    act_en = (state == S_RUN) && (act_tile < tiles) &&
             ((act_beat != '0) || (act_inflight < 16'(MAX_OUTSTANDING)));
    znz_en = (state == S_RUN) && (znz_tile < tiles) &&
             ((znz_beat != '0) || (znz_inflight < 16'(MAX_OUTSTANDING)));
    act_hs   = s_act_vld_i && m_act_rdy_i && act_en;
    znz_hs   = s_znz_vld_i && m_znz_rdy_i && znz_en;
    enc_hs   = mon_enc_vld_i && mon_enc_rdy_i;
    act_last = (act_beat == AB_W'(ACT_BEATS - 1));
    znz_last = (znz_beat == ZB_W'(ZNZ_BEATS - 1));
    enc_last = (enc_beat == EB_W'(ENC_BEATS - 1));
    max_tile = (act_tile > znz_tile) ? act_tile : znz_tile;
    // An output tile may never outrun the tiles actually fed to the wrapper.
    tile_out = enc_hs && active && enc_last && (tiles_done < max_tile);
    out_err  = enc_hs && (!active || (enc_last && (tiles_done >= max_tile)));
    tiles_done_nxt = tiles_done + 16'(tile_out);
  end

  assign m_act_data_o   = s_act_data_i;
  assign m_znz_data_o   = s_znz_data_i;
  assign m_act_vld_o    = s_act_vld_i && act_en;
  assign s_act_rdy_o    = m_act_rdy_i && act_en;
  assign m_znz_vld_o    = s_znz_vld_i && znz_en;
  assign s_znz_rdy_o    = m_znz_rdy_i && znz_en;
  assign cmd_rdy_o      = (state == S_IDLE);
  assign busy_o         = (state != S_IDLE);
  assign enable_o       = active;
  assign done_o         = (state == S_DONE);
  assign group_nz_sel_o = mode;
  assign err_o          = err;
  assign tiles_done_o   = tiles_done;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state      <= S_IDLE;
      tiles      <= '0;
      act_tile   <= '0;
      znz_tile   <= '0;
      tiles_done <= '0;
      act_beat   <= '0;
      znz_beat   <= '0;
      enc_beat   <= '0;
      mode       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_vld_i) begin
            tiles      <= cmd_tiles_i;
            mode       <= cmd_mode_i;
            act_tile   <= '0;
            znz_tile   <= '0;
            tiles_done <= '0;
            act_beat   <= '0;
            znz_beat   <= '0;
            enc_beat   <= '0;
            err        <= 1'b0;
            state      <= (cmd_tiles_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if ((act_tile == tiles) && (znz_tile == tiles)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Uses the post-edge count so the final output beat moves to DONE on its own edge.
          if (tiles_done_nxt == tiles) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (act_hs) begin
        act_beat <= act_last ? '0 : act_beat + AB_W'(1);
        if (act_last) act_tile <= act_tile + 16'd1;
      end
      if (znz_hs) begin
        znz_beat <= znz_last ? '0 : znz_beat + ZB_W'(1);
        if (znz_last) znz_tile <= znz_tile + 16'd1;
      end
      if (enc_hs && active) begin
        enc_beat <= enc_last ? '0 : enc_beat + EB_W'(1);
      end
      if (tile_out) tiles_done <= tiles_done_nxt;
      if (out_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zeroskip_tile_sched.sv
// Scoreboard bench for zeroskip_tile_sched. Each issued command pushes its
// expected completion record; a monitor loop models the wrapper (fixed output
// latency per completed input tile), counts stream handshakes and, on every
// done_o pulse, pops and compares the record.
module tb_zeroskip_tile_sched;
  localparam int AW  = 256;
  localparam int ZW  = 512;
  localparam int AB  = 16;
  localparam int ZB  = 1;
  localparam int EB  = 1;
  localparam int MO  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          a_rst_n;
  logic          cmd_vld_i, cmd_rdy_o, cmd_mode_i;
  logic [15:0]   cmd_tiles_i;
  logic [AW-1:0] s_act_data_i, m_act_data_o;
  logic          s_act_vld_i, s_act_rdy_o, m_act_vld_o, m_act_rdy_i;
  logic [ZW-1:0] s_znz_data_i, m_znz_data_o;
  logic          s_znz_vld_i, s_znz_rdy_o, m_znz_vld_o, m_znz_rdy_i;
  logic          mon_enc_vld_i, mon_enc_rdy_i;
  logic          enable_o, group_nz_sel_o, busy_o, done_o, err_o;
  logic [15:0]   tiles_done_o;

  always #5 clk = ~clk;

  zeroskip_tile_sched #(
    .ACT_DATA_W(AW), .ZNZ_DATA_W(ZW), .ACT_BEATS(AB),
    .ZNZ_BEATS(ZB), .ENC_BEATS(EB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
    .cmd_tiles_i(cmd_tiles_i), .cmd_mode_i(cmd_mode_i),
    .s_act_data_i(s_act_data_i), .s_act_vld_i(s_act_vld_i), .s_act_rdy_o(s_act_rdy_o),
    .m_act_data_o(m_act_data_o), .m_act_vld_o(m_act_vld_o), .m_act_rdy_i(m_act_rdy_i),
    .s_znz_data_i(s_znz_data_i), .s_znz_vld_i(s_znz_vld_i), .s_znz_rdy_o(s_znz_rdy_o),
    .m_znz_data_o(m_znz_data_o), .m_znz_vld_o(m_znz_vld_o), .m_znz_rdy_i(m_znz_rdy_i),
    .mon_enc_vld_i(mon_enc_vld_i), .mon_enc_rdy_i(mon_enc_rdy_i),
    .enable_o(enable_o), .group_nz_sel_o(group_nz_sel_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .tiles_done_o(tiles_done_o)
  );

  typedef struct {
    int tiles;
    int mode;
  } exp_t;

  exp_t sb[$];
  int   rq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   act_cnt = 0, znz_cnt = 0, enc_cnt = 0;
  int   cyc = 0, acc_cyc = 0, last_enc_cyc = 0, done_cnt = 0;
  int   pushed = 0, model_tiles = 0, rel_cnt = 0;
  bit   wrap_on = 1'b0, force_enc = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd_rdy", int'(cmd_rdy_o), 1);
    chk("rst_m_act_vld", int'(m_act_vld_o), 0);
    chk("rst_s_act_rdy", int'(s_act_rdy_o), 0);
    chk("rst_m_znz_vld", int'(m_znz_vld_o), 0);
    chk("rst_s_znz_rdy", int'(s_znz_rdy_o), 0);
    chk("rst_enable", int'(enable_o), 0);
    chk("rst_group_nz_sel", int'(group_nz_sel_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_tiles_done", int'(tiles_done_o), 0);
  endtask

  // Monitor and wrapper model: drive at the falling edge, sample 1 time unit later.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mon_enc_vld_i = force_enc ||
                      ((wrap_on || rel_cnt > 0) && rq.size() > 0 && rq[0] <= cyc);
      s_act_data_i = {8{$urandom}};
      s_znz_data_i = {16{$urandom}};
      #1;
      if (!a_rst_n) begin
        act_cnt = 0; znz_cnt = 0; enc_cnt = 0; pushed = 0; rq.delete();
      end
      if (cmd_vld_i && cmd_rdy_o) begin
        act_cnt = 0; znz_cnt = 0; enc_cnt = 0; pushed = 0; rq.delete();
        acc_cyc = cyc;
      end
      if (m_act_vld_o && m_act_rdy_i) begin
        act_cnt++;
        chk("act_data_pass", int'(m_act_data_o == s_act_data_i), 1);
      end
      if (m_znz_vld_o && m_znz_rdy_i) begin
        znz_cnt++;
        chk("znz_data_pass", int'(m_znz_data_o == s_znz_data_i), 1);
      end
      if (mon_enc_vld_i && mon_enc_rdy_i) begin
        enc_cnt++;
        last_enc_cyc = cyc;
        if (!force_enc) begin
          void'(rq.pop_front());
          if (!wrap_on && rel_cnt > 0) rel_cnt--;
        end
      end
      model_tiles = (act_cnt / AB < znz_cnt / ZB) ? act_cnt / AB : znz_cnt / ZB;
      while (pushed < model_tiles) begin
        rq.push_back(cyc + LAT);
        pushed++;
      end
      if (done_o) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("tiles_done", int'(tiles_done_o), e.tiles);
          chk("group_nz_sel", int'(group_nz_sel_o), e.mode);
          chk("act_beats", act_cnt, e.tiles * AB);
          chk("znz_beats", znz_cnt, e.tiles * ZB);
          chk("err_at_done", int'(err_o), 0);
          chk("done_latency", cyc - ((e.tiles == 0) ? acc_cyc : last_enc_cyc), 1);
        end
      end
    end
  end

  task automatic send_cmd(input int tiles, input bit mode, input bit expect_done);
    exp_t e;
    e.tiles = tiles;
    e.mode  = int'(mode);
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    cmd_tiles_i = 16'(tiles);
    cmd_mode_i  = mode;
    cmd_vld_i   = 1'b1;
    @(negedge clk);
    cmd_vld_i   = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int i;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done_o, expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    int d0;
    int i;
    a_rst_n = 1'b0;
    cmd_vld_i = 1'b0; cmd_tiles_i = '0; cmd_mode_i = 1'b0;
    s_act_vld_i = 1'b1; s_znz_vld_i = 1'b1;
    m_act_rdy_i = 1'b1; m_znz_rdy_i = 1'b1;
    mon_enc_rdy_i = 1'b1; mon_enc_vld_i = 1'b0;
    s_act_data_i = '0; s_znz_data_i = '0;
    #2;
    chk_reset_vals();
    @(negedge clk); #3; a_rst_n = 1'b1;

    // Basic run: 3 tiles, mode 1.
    wrap_on = 1'b1;
    d0 = done_cnt;
    send_cmd(3, 1'b1, 1'b1);
    wait_done(d0, 400);
    repeat (3) @(negedge clk);

    // Stray output handshake in IDLE.
    #3; force_enc = 1'b1;
    @(negedge clk); #3; force_enc = 1'b0;
    @(negedge clk); #2;
    chk("err_set_idle", int'(err_o), 1);
    chk("err_tiles_done_held", int'(tiles_done_o), 3);

    // Credit stall: 8 tiles, outputs withheld.
    wrap_on = 1'b0;
    d0 = done_cnt;
    send_cmd(8, 1'b1, 1'b1);
    #2;
    chk("err_cleared_on_accept", int'(err_o), 0);
    repeat (120) @(negedge clk);
    #2;
    chk("stall_act_beats", act_cnt, 4 * AB);
    chk("stall_znz_beats", znz_cnt, 4 * ZB);
    chk("stall_s_act_rdy", int'(s_act_rdy_o), 0);
    #1; rel_cnt = 1;
    repeat (60) @(negedge clk);
    #2;
    chk("release_enc_beats", enc_cnt, 1);
    chk("release_act_beats", act_cnt, 5 * AB);
    chk("release_znz_beats", znz_cnt, 5 * ZB);
    wrap_on = 1'b1;
    wait_done(d0, 600);
    repeat (3) @(negedge clk);

    // Command offered while busy must be ignored.
    d0 = done_cnt;
    send_cmd(2, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    cmd_tiles_i = 16'd5; cmd_mode_i = 1'b0; cmd_vld_i = 1'b1;
    #2;
    chk("busy_cmd_rdy", int'(cmd_rdy_o), 0);
    repeat (4) @(negedge clk);
    cmd_vld_i = 1'b0;
    wait_done(d0, 400);
    repeat (3) @(negedge clk);
    #2;
    chk("mode_held_idle", int'(group_nz_sel_o), 1);

    // Zero tiles, mode 0.
    d0 = done_cnt;
    send_cmd(0, 1'b0, 1'b1);
    #2;
    chk("zero_cmd_rdy_t1", int'(cmd_rdy_o), 0);
    chk("zero_done_t1", int'(done_o), 1);
    @(negedge clk); #2;
    chk("zero_cmd_rdy_t2", int'(cmd_rdy_o), 1);
    chk("zero_mode", int'(group_nz_sel_o), 0);
    wait_done(d0, 10);

    // Reset mid-run after 20 act beats.
    wrap_on = 1'b0;
    send_cmd(4, 1'b1, 1'b0);
    i = 0;
    while (act_cnt < 20 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("pre_reset_act_beats", act_cnt, 20);
    #3; a_rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk); #3; a_rst_n = 1'b1;
    wrap_on = 1'b1;
    d0 = done_cnt;
    send_cmd(1, 1'b1, 1'b1);
    wait_done(d0, 200);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/zeroskip_tile_sched.md
# zeroskip_tile_sched

Tile-level scheduler that sits in front of `zeroskip_pipe_wrapper_MAC256`. It accepts a command (tile count, sparsity mode) and gates the activation and ZNZ-mask input streams into the wrapper on tile boundaries. It bounds the number of tiles in flight inside the wrapper with a credit counter, and counts encoded-output beats to report completion. Stream data passes through combinationally; only valid/ready are gated.

## Interface
- `ACT_DATA_W`, 256: activation stream width (2*M*DATA_W, M=16, DATA_W=8).
- `ZNZ_DATA_W`, 512: ZNZ mask stream width (2*M*ROWS).
- `ACT_BEATS`, 16: activation beats per tile (≥1).
- `ZNZ_BEATS`, 1: ZNZ beats per tile (≥1).
- `ENC_BEATS`, 1: encoded-output beats per tile (≥1).
- `MAX_OUTSTANDING`, 4: maximum tiles started but not yet completed (1..255).
- `clk`  in  1  clock, all logic rising-edge.
- `a_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_vld_i`  in  1  command valid.
- `cmd_rdy_o`  out  1  command ready (high only in IDLE).
- `cmd_tiles_i`  in  16  tiles in this command (0 legal).
- `cmd_mode_i`  in  1  group_nz_sel for this command (1 = 8:16, 0 = 4:16).
- `s_act_data_i` / `s_act_vld_i` / `s_act_rdy_o`  in/in/out  ACT_DATA_W/1/1  upstream activation stream.
- `m_act_data_o` / `m_act_vld_o` / `m_act_rdy_i`  out/out/in  ACT_DATA_W/1/1  to wrapper `act_din*`.
- `s_znz_data_i` / `s_znz_vld_i` / `s_znz_rdy_o`  in/in/out  ZNZ_DATA_W/1/1  upstream mask stream.
- `m_znz_data_o` / `m_znz_vld_o` / `m_znz_rdy_i`  out/out/in  ZNZ_DATA_W/1/1  to wrapper `znz_din*`.
- `mon_enc_vld_i`, `mon_enc_rdy_i`  in  1 each  taps of the wrapper output handshake (monitor only, never driven).
- `enable_o`  out  1  wrapper `enable`.
- `group_nz_sel_o`  out  1  wrapper `group_nz_sel`.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  single-cycle completion pulse.
- `err_o`  out  1  sticky unexpected-output flag.
- `tiles_done_o`  out  16  tiles completed in the current or last command.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `cmd_rdy_o`=1.
  - On `cmd_vld_i`: latch tiles and mode, clear all counters, `tiles_done_o` and `err_o`.
  - Go to DONE if tiles==0, else RUN.
- RUN:
  - `enable_o`=1.
  - Go to DRAIN once both act and znz tile indices equal tiles.
- DRAIN:
  - `enable_o`=1.
  - Go to DONE when `tiles_done_o`==tiles.
- DONE: `done_o`=1 for one cycle, then IDLE. `enable_o`=0 in IDLE/DONE.
- `group_nz_sel_o` is registered. It updates only on command accept and is held through DONE and IDLE.
- Per-stream counters, act shown (znz identical with ZNZ_BEATS):
  - `act_beat` counts 0..ACT_BEATS-1 on each `m_act` handshake.
  - `act_tile` increments when the last beat of a tile is accepted.
- Stream gating, act shown (znz identical):
  - `act_en` = (state==RUN) & (act_tile < tiles) & (act_beat≠0 | (act_tile − tiles_done) < MAX_OUTSTANDING).
  - `m_act_vld_o` = `s_act_vld_i` & `act_en`; `s_act_rdy_o` = `m_act_rdy_i` & `act_en`; data passes straight through.
  - A tile in progress is never blocked mid-tile. The credit check applies only at the first beat of a tile.
- Output counting:
  - `enc_beat` counts 0..ENC_BEATS-1 on each `mon_enc_vld_i & mon_enc_rdy_i`.
  - `tiles_done_o` increments on the last beat of a tile.
- Error: an output handshake in IDLE or DONE, or one that would take `tiles_done_o` past max(`act_tile`, `znz_tile`), sets `err_o`. In that case the counter is not incremented. `err_o` stays set until the next command accept.
- Commands offered while busy are ignored, since `cmd_rdy_o`=0.

## Timing
- Reset values:
  - `cmd_rdy_o`=1.
  - 0 on all other outputs: `m_*_vld_o`, `s_*_rdy_o`, `enable_o`, `group_nz_sel_o`, `busy_o`, `done_o`, `err_o`, `tiles_done_o`.
  - FSM in IDLE.
- Command accepted at edge t:
  - RUN from t+1; the first gated beat can pass in cycle t+1.
  - tiles==0: `done_o` is high in cycle t+1, then IDLE at t+2.
- Gating is combinational from registered state and counters: zero added latency and no bubbles while credits are available.
- A credit released by a completing output beat at edge t is usable in cycle t+1.
- An output tile completing on the same edge as a new tile start: the start uses the pre-edge count. No combinational path from `mon_enc_*` to `m_*_vld_o`.
- Last output beat at edge t: DRAIN→DONE at t, `done_o` high in cycle t+1, IDLE at t+2.
- If the final output arrives while still in RUN (streams finishing late), the FSM takes DRAIN for one cycle minimum before DONE.
- `a_rst_n` asserted mid-RUN: all outputs go to reset values immediately (asynchronously) and any partial tile is abandoned. After release the block is in IDLE.

## Test plan
- Basic run (defaults, tiles=3, mode=1, all streams always valid/ready, wrapper returns 1 output beat per tile): 48 act beats and 3 znz beats pass; `group_nz_sel_o`=1; `tiles_done_o`=3; `done_o` pulses exactly once, the cycle after the 3rd output beat.
- Credit stall (tiles=8, `mon_enc_vld_i` held 0): exactly 64 act and 4 znz beats pass, then `s_act_rdy_o`=0. Releasing one output beat admits exactly one more tile (16 act beats). The run ends with `tiles_done_o`=8.
- Zero tiles (tiles=0): no stream handshakes; `done_o` high at t+1; `cmd_rdy_o` high again at t+2.
- Busy command (command offered mid-run with mode=0): not accepted; `group_nz_sel_o` stays 1 until the next command accepted from IDLE.
- Error (output handshake while IDLE): `err_o`=1 and `tiles_done_o` unchanged; the next command accept clears `err_o`.
- Reset mid-run (reset pulsed after 20 act beats): every output is at its reset value during reset. A new command of tiles=1 afterwards completes normally with 16 act beats.
